gcd_unit_ctrl: RTL
==================

GCD_UNIT_CTRL -- requirements
Module: gcd_unit_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk is the clock, and reset is asynchronous and active-high.
REQ-002 Parameter: CW, default 8, width of the optional iteration counter.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 in_val  in  1  operand request valid; the datapath in_A/in_B carry the operands.
REQ-006 in_rdy  out  1  control is ready to accept operands.
REQ-007 out_val  out  1  result valid; the datapath out carries the result.
REQ-008 out_rdy  in  1  consumer accepts the result.
REQ-009 sel_A  out  2  A mux select to the datapath: 0=in_A, 1=B_reg, 2=A_reg-B_reg.
REQ-010 sel_B  out  1  B mux select to the datapath: 0=in_B, 1=A_reg.
REQ-011 en_A, en_B  out  1 each  datapath register write enables.
REQ-012 is_A_lt_B, is_B_neq_0  in  1 each  datapath status flags.
REQ-013 iter_count  out  CW  iteration count; present only under GCD_UNIT_CTRL_ITER_EN.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and DONE, held in a single state register.
REQ-015 IDLE behaviour:
- in_rdy=1, out_val=0.
- If in_val=1, then sel_A=0, sel_B=0, en_A=1, en_B=1, and the next state is CALC.
- Otherwise en_A=en_B=0 and the FSM stays in IDLE.
REQ-016 CALC behaviour when is_A_lt_B=1 (swap step): sel_A=1, sel_B=1, en_A=1, en_B=1; stay in CALC.
REQ-017 CALC behaviour when is_A_lt_B=0 and is_B_neq_0=1 (subtract step): sel_A=2, en_A=1, en_B=0; stay in CALC.
REQ-018 CALC behaviour when is_A_lt_B=0 and is_B_neq_0=0 (terminate): en_A=en_B=0; next state is DONE.
- In all CALC cycles, in_rdy=0 and out_val=0.
REQ-019 DONE behaviour:
- out_val=1, in_rdy=0, en_A=en_B=0.
- If out_rdy=1, the next state is IDLE; otherwise the FSM holds DONE and the result stays stable.
REQ-020 All outputs SHALL be combinational functions of the current state and the inputs, with no registered output delay.
- The FSM never accepts a new operand in the same cycle that it delivers a result.
REQ-021 When enables are 0, don't-care selects SHALL be driven to 0 (never X).
REQ-022 Latency SHALL be 1 accept cycle + (steps+1) CALC cycles + at least 1 DONE cycle, where steps = the number of swap and subtract cycles.
REQ-023 in_val and out_rdy SHALL be ignored in every state where they have no defined effect.

Reset
REQ-024 While reset=1, the state SHALL be forced to IDLE immediately (asynchronously).
- Outputs during reset: in_rdy=0, out_val=0, en_A=0, en_B=0, sel_A=0, sel_B=0, iter_count=0.
- in_rdy rises in the first cycle after reset deasserts.
REQ-025 Reset asserted in CALC or DONE SHALL abandon the operation; no out_val is produced for it.

Configuration
REQ-026 Under macro GCD_UNIT_CTRL_ITER_EN, the block SHALL add the iter_count port and its CW-bit register:
- Cleared to 0 on the accepting cycle in IDLE.
- Incremented on every swap or subtract cycle in CALC.
- Saturates at 2^CW-1.
- Held stable through DONE and IDLE until the next accept.
REQ-027 Without GCD_UNIT_CTRL_ITER_EN, the port and register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 A=15, B=5, out_rdy=1:
- Required: 5 CALC cycles (sub, sub, sub, swap, terminate).
- out_val=1 in the 7th cycle counting the accept cycle as 1.
- Datapath out=5; iter_count=4.
REQ-029 A=0, B=7:
- Required: swap then terminate (2 CALC cycles); out=7; iter_count=1.
- A=0, B=0 instead: a single CALC cycle; out=0; iter_count=0.
REQ-030 Hold out_rdy=0 for 10 cycles in DONE:
- out_val=1 and in_rdy=0 throughout; en_A=en_B=0; out stable.
- Then out_rdy=1 gives IDLE next cycle; a new operand is accepted the following cycle.
REQ-031 Assert reset for 1 cycle during CALC of A=27, B=9:
- Required: IDLE immediately, in_rdy=1 after release, no out_val for the aborted operation.
- The next request A=27, B=9 yields out=9.
REQ-032 CW=2, A=15, B=1 (macro on): 16 steps; iter_count saturates at 3; out=1.
REQ-033 Back-to-back requests with in_val held high: each accept only occurs in IDLE, and the results 5, then 9, then 1 are delivered in order.

Source files
------------

// File: rtl/gcd_unit_ctrl.sv
// gcd_unit_ctrl: control FSM for an iterative subtract-and-swap GCD datapath.
// The FSM accepts an operand pair in IDLE, steers the datapath muxes and
// register enables through swap/subtract steps in CALC, then presents the
// result in DONE until the consumer takes it.
// Optional feature: define GCD_UNIT_CTRL_ITER_EN to add the saturating
// iteration counter and its iter_count output port.
module gcd_unit_ctrl #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_val,
  output logic          in_rdy,
  output logic          out_val,
  input  logic          out_rdy,
  output logic [1:0]    sel_A,
  output logic          sel_B,
  output logic          en_A,
  output logic          en_B,
  input  logic          is_A_lt_B,
  input  logic          is_B_neq_0
`ifdef GCD_UNIT_CTRL_ITER_EN
  ,
  output logic [CW-1:0] iter_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // datapath mux encodings
  localparam logic [1:0] SEL_A_IN  = 2'd0;
  localparam logic [1:0] SEL_A_B   = 2'd1;
  localparam logic [1:0] SEL_A_SUB = 2'd2;
  localparam logic       SEL_B_IN  = 1'b0;
  localparam logic       SEL_B_A   = 1'b1;

  state_t state_q;
  state_t state_d;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore/Mealy outputs; reset forces every output low.
  always_comb begin
    state_d = state_q;
    in_rdy  = 1'b0;
    out_val = 1'b0;
    sel_A   = SEL_A_IN;
    sel_B   = SEL_B_IN;
    en_A    = 1'b0;
    en_B    = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_val) begin
          sel_A   = SEL_A_IN;
          sel_B   = SEL_B_IN;
          en_A    = 1'b1;
          en_B    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (is_A_lt_B) begin
          sel_A = SEL_A_B;
          sel_B = SEL_B_A;
          en_A  = 1'b1;
          en_B  = 1'b1;
        end else if (is_B_neq_0) begin
          sel_A = SEL_A_SUB;
          en_A  = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_val = 1'b1;
        if (out_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (reset) begin
      state_d = IDLE;
      in_rdy  = 1'b0;
      out_val = 1'b0;
      sel_A   = SEL_A_IN;
      sel_B   = SEL_B_IN;
      en_A    = 1'b0;
      en_B    = 1'b0;
    end
  end

`ifdef GCD_UNIT_CTRL_ITER_EN
  logic [CW-1:0] iter_q;
  logic          iter_clear;
  logic          iter_step;

  assign iter_clear = in_rdy && in_val;
  assign iter_step  = (state_q == CALC) && (is_A_lt_B || is_B_neq_0);

  // Iteration counter: cleared on accept, counts swap/subtract steps, saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iter_q <= '0;
    end else if (iter_clear) begin
      iter_q <= '0;
    end else if (iter_step && (iter_q != '1)) begin
      iter_q <= iter_q + 1'b1;
    end
  end

  assign iter_count = iter_q;
`endif

endmodule
